// File: rtl/pipeline_run_ctrl.sv
// Run/step/halt controller for a pipelined core with clock-enable gating and performance counters.
// Optional breakpoint logic is compiled in when RUN_CTRL_BREAKPOINT_EN is defined.
module pipeline_run_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_req,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic [15:0] step_count,
    input  logic        core_halt,
    input  logic [31:0] pc,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic        branch_stall,
    input  logic        load_stall,
    input  logic        cnt_clr,
    output logic        cpu_clk_en,
    output logic [1:0]  state,
    output logic [1:0]  halt_cause,
    output logic        step_done,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count,
    output logic [31:0] load_stall_count,
    output logic [31:0] branch_stall_count
);

    // state | meaning
    // IDLE  | out of reset, core clock gated
    // RUN   | free-running until halt_req, core_halt or breakpoint
    // STEP  | running for 'remaining' enabled cycles
    // HALT  | stopped; halt_cause records why
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      cur;
    logic [15:0] remaining;
    logic        bp_hit;

    assign state = cur;

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic bp_skip;
    // bp_skip lets a core resumed from a breakpoint execute the breakpoint PC once
    assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_en, bp_addr, pc};
    assign bp_hit    = 1'b0;
`endif

    assign cpu_clk_en = ((cur == S_RUN) || (cur == S_STEP)) && !bp_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= S_IDLE;
            halt_cause <= 2'd0;
            step_done  <= 1'b0;
            remaining  <= 16'd0;
`ifdef RUN_CTRL_BREAKPOINT_EN
            bp_skip    <= 1'b0;
`endif
        end else begin
            step_done <= 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
            if (cpu_clk_en) begin
                bp_skip <= 1'b0;
            end
`endif
            case (cur)
                S_IDLE, S_HALT: begin
                    if (halt_req) begin
                        cur <= cur;
                    end else if (step_req) begin
                        if (step_count != 16'd0) begin
                            cur        <= S_STEP;
                            remaining  <= step_count;
                            halt_cause <= 2'd0;
`ifdef RUN_CTRL_BREAKPOINT_EN
                            bp_skip    <= (halt_cause == 2'd3);
`endif
                        end
                    end else if (run_req) begin
                        cur        <= S_RUN;
                        halt_cause <= 2'd0;
`ifdef RUN_CTRL_BREAKPOINT_EN
                        bp_skip    <= (halt_cause == 2'd3);
`endif
                    end
                end
                S_RUN: begin
                    if (halt_req) begin
                        cur        <= S_HALT;
                        halt_cause <= 2'd1;
                    end else if (core_halt && cpu_clk_en) begin
                        cur        <= S_HALT;
                        halt_cause <= 2'd2;
                    end else if (bp_hit) begin
                        cur        <= S_HALT;
                        halt_cause <= 2'd3;
                    end
                end
                S_STEP: begin
                    if (halt_req) begin
                        cur        <= S_HALT;
                        halt_cause <= 2'd1;
                        remaining  <= 16'd0;
                    end else if (core_halt && cpu_clk_en) begin
                        cur        <= S_HALT;
                        halt_cause <= 2'd2;
                        remaining  <= 16'd0;
                    end else if (bp_hit) begin
                        cur        <= S_HALT;
                        halt_cause <= 2'd3;
                        remaining  <= 16'd0;
                    end else if (cpu_clk_en) begin
                        if (remaining == 16'd1) begin
                            cur        <= S_HALT;
                            halt_cause <= 2'd0;
                            step_done  <= 1'b1;
                            remaining  <= 16'd0;
                        end else begin
                            remaining <= remaining - 16'd1;
                        end
                    end
                end
                default: begin
                    cur <= S_IDLE;
                end
            endcase
        end
    end

    // Clear wins over any same-edge increment; counters wrap freely
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            cycle_count        <= 32'd0;
            instr_count        <= 32'd0;
            load_stall_count   <= 32'd0;
            branch_stall_count <= 32'd0;
        end else if (cpu_clk_en) begin
            cycle_count <= cycle_count + 32'd1;
            if (branch_stall) begin
                branch_stall_count <= branch_stall_count + 32'd1;
            end else begin
                instr_count <= instr_count + 32'd1;
            end
            if (load_stall) begin
                load_stall_count <= load_stall_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/pipeline_run_ctrl.md
PIPELINE_RUN_CTRL -- requirements
Module: pipeline_run_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk (input, 1) is the sole clock; reset (input, 1) is synchronous and active-high.
REQ-002 SHALL have ports, one per line as: name  direction  width  meaning:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- run_req  in  1  start free-running
- halt_req  in  1  stop core
- step_req  in  1  run step_count core cycles
- step_count  in  16  step length, sampled on accepted step_req
- core_halt  in  1  halt instruction decoded by core
- pc  in  32  core PC register
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC
- branch_stall  in  1  core cycle is a branch/jump stall
- load_stall  in  1  core cycle is a load-use stall
- cnt_clr  in  1  clear performance counters
- cpu_clk_en  out  1  core clock enable
- state  out  2  IDLE=0, RUN=1, STEP=2, HALT=3
- halt_cause  out  2  0 step-done/none, 1 halt_req, 2 core_halt, 3 breakpoint
- step_done  out  1  one-cycle pulse at step completion
- cycle_count, instr_count, load_stall_count, branch_stall_count  out  32 each  performance counters

Function
REQ-003 SHALL drive cpu_clk_en = (state==RUN or state==STEP) and not bp_hit, with no other input path.
REQ-004 SHALL define bp_hit = bp_en and (pc==bp_addr) and not bp_skip.
REQ-005 SHALL make all state changes registered; a request sampled at edge k takes effect in state from edge k, so cpu_clk_en falls one cycle after halt_req.
REQ-006 SHALL resolve simultaneous requests with priority halt_req > step_req > run_req; cnt_clr is independent of requests.
REQ-007 SHALL, in IDLE or HALT: on run_req go to RUN; on step_req with step_count!=0 go to STEP and load remaining=step_count; on step_req with step_count==0 stay in place with no step_done.
REQ-008 SHALL, in RUN: ignore run_req and step_req; go to HALT on halt_req (cause 1), core_halt while cpu_clk_en=1 (cause 2), or bp_hit (cause 3).
REQ-009 SHALL, in STEP: decrement remaining on each cpu_clk_en=1 cycle; when remaining==1 and cpu_clk_en=1, go to HALT with cause 0 and pulse step_done.
REQ-010 SHALL, in STEP, also apply the REQ-008 exits; halt_req, core_halt or bp_hit take precedence over step completion, and step_done is then not pulsed.
REQ-011 SHALL hold halt_cause while in HALT and clear it to 0 on leaving HALT.
REQ-012 SHALL set bp_skip when leaving HALT with halt_cause==3, and clear it after the first cpu_clk_en=1 cycle, so a resumed core advances past the breakpoint PC.
REQ-013 SHALL, on each cpu_clk_en=1 cycle: increment cycle_count; increment branch_stall_count if branch_stall, else instr_count; increment load_stall_count if load_stall.
REQ-014 SHALL let all counters wrap from 0xFFFFFFFF to 0 with no saturation or flag.
REQ-015 SHALL zero all four counters on the edge where cnt_clr=1, overriding any same-cycle increment.

Reset
REQ-016 SHALL on reset set: state=IDLE, cpu_clk_en=0, halt_cause=0, step_done=0, remaining=0, bp_skip=0, all counters=0.
REQ-017 SHALL let reset override every request, including when asserted mid-RUN or mid-STEP.

Configuration
REQ-018 SHALL gate breakpoint logic with macro RUN_CTRL_BREAKPOINT_EN.
- Defined: REQ-004 and REQ-012 apply.
- Undefined: bp_hit is constant 0, bp_skip is absent, halt_cause never equals 3, bp_en and bp_addr remain as ports and are ignored.

Verification
REQ-019 SHALL cover step: reset, step_req with step_count=5 -> exactly 5 cpu_clk_en cycles, step_done pulses once, state=HALT, halt_cause=0, cycle_count=5.
REQ-020 SHALL cover breakpoint (macro defined): bp_en=1, bp_addr=0x10, run_req, pc reaches 0x10 -> cpu_clk_en=0 that cycle, HALT cause 3; then run_req -> exactly one cycle at pc 0x10 enabled and pc advances.
REQ-021 SHALL cover request priority: halt_req, step_req and run_req together in IDLE -> state stays out of RUN/STEP; in RUN, halt_req -> HALT cause 1 next edge.
REQ-022 SHALL cover counters: RUN for 10 cycles with branch_stall high on 3 and load_stall high on 2 -> cycle=10, branch=3, instr=7, load=2; cnt_clr with increment same edge -> all 0.
REQ-023 SHALL cover wrap: cycle_count forced to 0xFFFFFFFF and one enabled cycle -> 0.
REQ-024 SHALL cover reset mid-STEP: step_count=100, reset after 20 cycles -> IDLE, all counters 0, no step_done.
